// File: rtl/rr_mux_arb.sv
// rr_mux_arb: registered N:1 word selector with valid/ready on every channel.
// Two arbitration modes: round-robin (mode=0) rotating after the last grant,
// and fixed select (mode=1) taking the channel named by i_sel. One output
// register sits between the arbitrated input and the consumer; it can be
// popped and refilled in the same cycle, giving one word per cycle.
//
// Handshake rule for every channel: a word moves on a rising edge exactly
// when valid and ready are both 1 in the cycle before that edge. Valid must
// not depend on ready; o_in_ready depends combinationally on i_in_valid,
// i_mode, i_sel, i_out_ready and the registered state, so the consumer must
// not make i_out_ready depend on o_in_ready.
module rr_mux_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 32,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [CHANNELS-1:0]       i_in_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    output logic [CHANNELS-1:0]       o_in_ready,
    output logic                      o_out_valid,
    output logic [WIDTH-1:0]          o_out_data,
    output logic [SEL_W-1:0]          o_out_sel,
    input  logic                      i_out_ready,
    // Round-robin pointer, exposed so checkers can observe arbitration state.
    output logic [SEL_W-1:0]          o_last_grant
);

    // After reset the pointer sits on the last channel so channel 0 wins first.
    localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(CHANNELS - 1);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic [SEL_W-1:0]    r_last_grant;

    logic                w_free;
    logic                w_fix_vld;
    logic                w_rr_vld;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_grant_vld;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]    w_grant_data;
    logic [CHANNELS-1:0] w_ready;
    logic                w_xfer;

    // The output register can take a new word when empty or being drained.
    assign w_free = !r_out_valid || i_out_ready;

    // Fixed select: only an in-range index whose channel is valid is granted.
    always_comb begin
        w_fix_vld = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(i_sel) == i && i_in_valid[i]) begin
                w_fix_vld = 1'b1;
            end
        end
    end

    // Round-robin search from last_grant+1 upward, wrapping at CHANNELS, so
    // the previously granted channel is considered last. Indices are folded
    // explicitly so a non-power-of-two channel count never goes out of range.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            int j;
            j = int'(r_last_grant) + k;
            if (j >= CHANNELS) begin
                j = j - CHANNELS;
            end
            if (!w_rr_vld && i_in_valid[j]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = SEL_W'(j);
            end
        end
    end

    // Pick the active mode's candidate.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (i_mode) begin
            w_grant_vld = w_fix_vld;
            w_grant_idx = i_sel;
        end else begin
            w_grant_vld = w_rr_vld;
            w_grant_idx = w_rr_idx;
        end
    end

    // Data mux and one-hot ready; equality compare keeps every index in range.
    always_comb begin
        w_grant_data = '0;
        w_ready      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(w_grant_idx) == i) begin
                w_grant_data = i_in_data[i*WIDTH +: WIDTH];
                w_ready[i]   = w_free && w_grant_vld;
            end
        end
    end

    // A grant always targets a valid channel, so free+grant is a transfer.
    assign w_xfer = w_free && w_grant_vld;

    // Output register and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sel    <= '0;
            r_last_grant <= LAST_INIT;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_sel   <= w_grant_idx;
            if (!i_mode) begin
                r_last_grant <= w_grant_idx;
            end
        end else if (w_free) begin
            // Drained with nothing to replace it: data and sel keep old values.
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready   = w_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_sel    = r_out_sel;
    assign o_last_grant = r_last_grant;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb with a 5-channel (non-power-of-two) instance.
module tb_rr_mux_arb;

  localparam int W     = 32;
  localparam int C     = 5;
  localparam int SEL_W = $clog2(C);

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [C-1:0]     in_valid;
  logic [C*W-1:0]   in_data;
  logic [C-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_ready;
  logic [SEL_W-1:0] last_grant;

  rr_mux_arb #(.WIDTH(W), .CHANNELS(C), .SEL_W(SEL_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mode       (mode),
    .i_sel        (sel),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_out_sel    (out_sel),
    .i_out_ready  (out_ready),
    .o_last_grant (last_grant)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // scoreboard: {sel, data} of each accepted word
  logic [SEL_W+W-1:0] exp_q[$];
  logic               m_ov;
  logic [SEL_W-1:0]   m_last;

  // ---------------- drivers ----------------
  task automatic set_data_pattern();
    for (int i = 0; i < C; i++) in_data[i*W +: W] = W'(32'hA0 + i);
  endtask

  task automatic set_data_random();
    for (int i = 0; i < C; i++) in_data[i*W +: W] = $urandom;
  endtask

  // Called at posedge+1; asynchronously resets DUT and model.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ov   = 1'b0;
    m_last = SEL_W'(C - 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: reference arbitration at negedge, scoreboard pop/push,
  // then advance to posedge+1.
  task automatic sb_cycle();
    logic             free;
    logic             g_vld;
    logic [SEL_W-1:0] g_idx;
    logic [C-1:0]     exp_ready;
    logic [SEL_W+W-1:0] front;
    @(negedge clk);
    free  = !m_ov || out_ready;
    g_vld = 1'b0;
    g_idx = '0;
    if (mode) begin
      if (int'(sel) < C) begin
        if (in_valid[sel]) begin
          g_vld = 1'b1;
          g_idx = sel;
        end
      end
    end else begin
      for (int k = 1; k <= C; k++) begin
        int j;
        j = (int'(m_last) + k) % C;
        if (!g_vld && in_valid[j]) begin
          g_vld = 1'b1;
          g_idx = SEL_W'(j);
        end
      end
    end
    exp_ready = '0;
    if (free && g_vld) exp_ready[g_idx] = 1'b1;
    n_cmp++;
    if (in_ready !== exp_ready) begin
      n_err++;
      $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, exp_ready);
    end
    n_cmp++;
    if (out_valid !== m_ov) begin
      n_err++;
      $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_ov);
    end
    if (m_ov && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty @%0t: got sel %0d data %h, want nothing", $time, out_sel, out_data);
      end else begin
        front = exp_q.pop_front();
        if ({out_sel, out_data} !== front) begin
          n_err++;
          $display("FAIL sb_word @%0t: got sel %0d data %h want sel %0d data %h",
                   $time, out_sel, out_data, front[SEL_W+W-1:W], front[W-1:0]);
        end
      end
    end
    if (free) begin
      if (g_vld) begin
        exp_q.push_back({g_idx, in_data[int'(g_idx)*W +: W]});
        if (!mode) m_last = g_idx;
      end
      m_ov = g_vld;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; set_data_pattern();
    rst_n = 1'b0;
    m_ov = 1'b0; m_last = SEL_W'(C - 1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (out_data !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_cmp++;
    if (out_sel !== '0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", out_sel); end
    n_cmp++;
    if (last_grant !== SEL_W'(C - 1)) begin
      n_err++; $display("FAIL rst_last: got %0d want %0d", last_grant, C - 1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    in_valid = '0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sb_cycle();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== '0) begin
        n_err++;
        $display("FAIL idle: got v=%b d=%h r=%b want v=0 d=0 r=0", out_valid, out_data, in_ready);
      end
    end
  endtask

  task automatic test_rr_all();
    mode = 1'b0; in_valid = '1; out_ready = 1'b1; set_data_pattern();
    for (int k = 0; k < 12; k++) begin
      sb_cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || out_sel !== SEL_W'(k % C) || out_data !== W'(32'hA0 + k % C)) begin
        n_err++;
        $display("FAIL rr_seq[%0d]: got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h",
                 k, out_valid, out_sel, out_data, k % C, 32'hA0 + k % C);
      end
    end
  endtask

  task automatic test_rr_sparse();
    do_reset();
    mode = 1'b0; in_valid = 5'b01010; out_ready = 1'b1; set_data_pattern();
    for (int k = 0; k < 6; k++) begin
      logic [SEL_W-1:0] want;
      want = (k % 2 == 0) ? SEL_W'(1) : SEL_W'(3);
      sb_cycle();
      n_cmp++;
      if (out_sel !== want || out_data !== W'(32'hA0) + W'(want)) begin
        n_err++;
        $display("FAIL rr_sparse[%0d]: got sel=%0d d=%h want sel=%0d", k, out_sel, out_data, want);
      end
    end
  endtask

  task automatic test_fixed();
    logic [SEL_W-1:0] ptr;
    ptr = m_last;
    mode = 1'b1; sel = 3'd2; in_valid = '1; out_ready = 1'b1; set_data_pattern();
    for (int k = 0; k < 4; k++) begin
      sb_cycle();
      n_cmp++;
      if (out_sel !== 3'd2 || out_data !== 32'hA2) begin
        n_err++; $display("FAIL fix_sel2[%0d]: got sel=%0d d=%h want sel=2 d=a2", k, out_sel, out_data);
      end
    end
    sel = 3'd3;
    sb_cycle();
    n_cmp++;
    if (out_sel !== 3'd3 || out_data !== 32'hA3) begin
      n_err++; $display("FAIL fix_sel3: got sel=%0d d=%h want sel=3 d=a3", out_sel, out_data);
    end
    for (int s = 5; s < 8; s++) begin
      sel = SEL_W'(s);
      #1;
      n_cmp++;
      if (in_ready !== '0) begin
        n_err++; $display("FAIL fix_oor_ready sel=%0d: got %b want 0", s, in_ready);
      end
      sb_cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL fix_oor_valid sel=%0d: got %b want 0", s, out_valid);
      end
    end
    n_cmp++;
    if (last_grant !== ptr) begin
      n_err++; $display("FAIL fix_ptr: got %0d want %0d", last_grant, ptr);
    end
    mode = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0]     hold_d;
    logic [SEL_W-1:0] hold_s;
    mode = 1'b0; in_valid = '1; out_ready = 1'b1; set_data_pattern();
    sb_cycle();
    hold_d = out_data; hold_s = out_sel;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sb_cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== hold_d || out_sel !== hold_s) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h",
                 k, out_valid, out_sel, out_data, hold_s, hold_d);
      end
    end
    #1;
    n_cmp++;
    if (in_ready !== '0) begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    sb_cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_sel !== SEL_W'((int'(hold_s) + 1) % C)) begin
      n_err++;
      $display("FAIL stall_resume: got v=%b sel=%0d want v=1 sel=%0d", out_valid, out_sel, (int'(hold_s) + 1) % C);
    end
  endtask

  task automatic test_reset_stall();
    mode = 1'b0; in_valid = '1; out_ready = 1'b0; set_data_pattern();
    sb_cycle();
    sb_cycle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || last_grant !== SEL_W'(C - 1)) begin
      n_err++;
      $display("FAIL rst_stall: got v=%b last=%0d want v=0 last=%0d", out_valid, last_grant, C - 1);
    end
    exp_q.delete();
    m_ov = 1'b0; m_last = SEL_W'(C - 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    sb_cycle();
    n_cmp++;
    if (out_sel !== '0 || out_data !== 32'hA0) begin
      n_err++; $display("FAIL rst_first: got sel=%0d d=%h want sel=0 d=a0", out_sel, out_data);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = SEL_W'($urandom_range(0, 7));
      in_valid  = C'($urandom_range(0, (1 << C) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      set_data_random();
      sb_cycle();
    end
    mode = 1'b0; in_valid = '0; out_ready = 1'b1;
    repeat (3) sb_cycle();
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL drain: got %0d pending v=%b want 0 pending v=0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_idle();
    test_rr_all();
    test_rr_sparse();
    test_fixed();
    test_stall();
    test_reset_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised, registered N:1 word selector with valid/ready handshaking on every channel. It is the sequential successor to the processor's fixed 1-bit mux tree. It supports a round-robin arbitration mode and a fixed-select mode, and it places one output pipeline register between the arbitrated input and the consumer. Typical uses are merging request streams, such as memory or I/O clients, into one shared datapath port.

## Interface
- WIDTH, 32, data bits per channel
- CHANNELS, 32, number of input channels (≥2, need not be a power of two)
- SEL_W, $clog2(CHANNELS), width of select/index fields
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- mode  input  1  0 = round-robin, 1 = fixed select
- sel  input  SEL_W  channel index used when mode=1
- in_valid  input  CHANNELS  per-channel valid, bit i = channel i
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  per-channel accept (combinational, one-hot or zero)
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered word
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Output register state: out_valid, out_data, out_sel, plus the round-robin pointer last_grant (SEL_W bits).
- free = !out_valid || out_ready. Arbitration happens only when free = 1. Otherwise all in_ready = 0.
- Mode 1 (fixed select):
  - grant = sel, provided sel < CHANNELS and in_valid[sel] = 1.
  - Otherwise there is no grant.
  - last_grant is not modified.
- Mode 0 (round-robin):
  - grant = first i with in_valid[i] = 1, searching last_grant+1, last_grant+2, … and wrapping modulo CHANNELS.
  - last_grant itself is searched last.
  - If no channel is valid, there is no grant.
- in_ready[grant] = 1 when free and a grant exists. All other in_ready bits = 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On that clock edge:
  - out_data ← channel g data
  - out_sel ← g
  - out_valid ← 1
  - if mode = 0, last_grant ← g
- If free and there is no grant: out_valid ← 0. out_data and out_sel hold their previous values.
- Stall: if out_valid && !out_ready, out_valid, out_data and out_sel hold, and no input is accepted.
- Wrap-around: the pointer at CHANNELS-1 resumes the search at 0. Non-power-of-two CHANNELS never indexes ≥ CHANNELS.
- Mode or sel changes take effect at the next arbitration cycle. A word already in the output register is unaffected.
- The block never drops or duplicates a word. Each input handshake yields exactly one output handshake.

## Timing
- Reset (reset = 0, asynchronous):
  - out_valid = 0
  - out_data = 0
  - out_sel = 0
  - last_grant = CHANNELS-1, so channel 0 wins first in round-robin
  - in_ready follows its combinational equation (all 1-side gated by grant; with out_valid = 0 it may assert)
- Deassertion of reset is synchronised by the parent. The first arbitration occurs on the first rising edge with reset = 1.
- Latency: an input accepted at edge k appears on out_valid/out_data immediately after edge k, and is consumable at edge k+1.
- Throughput: 1 word/cycle when out_ready is held 1. A simultaneous output pop and input push in the same cycle is permitted.
- in_ready depends combinationally on in_valid, mode, sel, out_valid, out_ready and last_grant. The consumer must not make out_ready depend on in_ready.
- Reset mid-stall: the held word is discarded, out_valid drops immediately and the pointer is restored.

## Test plan
- Reset, then all in_valid = 0 for 5 cycles -> out_valid stays 0, out_data = 0, in_ready = 0.
- CHANNELS=4, mode=0, all valid constantly, out_ready = 1, data_i = 0xA0+i -> out_sel sequence 0,1,2,3,0,1…, one word/cycle, out_data matches the channel.
- mode=0, in_valid = 4'b1010, last_grant = 3 -> grant 1, then 3, then 1. Channels 0 and 2 are never granted.
- mode=1, sel = 2, all valid -> every output has out_sel = 2. Switching sel = 3 -> the next accept is from channel 3. sel = 5 with CHANNELS = 4 -> no grant.
- out_ready low for 3 cycles while out_valid = 1 -> out_data/out_sel stable, in_ready = 0. out_ready rises -> pop and new push in the same cycle, no loss.
- Assert reset during a stall with out_valid = 1 -> out_valid = 0 immediately. After release with all valid, the first grant is channel 0.
